// File: rtl/piano_note_scheduler_pkg.sv
// piano_pkg: shared types and constants for the piano note scheduler.
//   NUM_NOTES       number of entries in the note table (C4..C5)
//   note_idx_t      index into the note table
//   sched_state_t   scheduler FSM states
//   NOTE_HALF       half-period counts for a 100 MHz clock, round(100e6/(2f)) - 1
//   note_table_fits elaboration check that every table entry fits a given count width
package piano_pkg;

    localparam int NUM_NOTES = 8;

    typedef logic [2:0] note_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } sched_state_t;

    localparam int unsigned NOTE_HALF [0:NUM_NOTES-1] = '{
        191109,  // C4
        170264,  // D4
        151684,  // E4
        143171,  // F4
        127550,  // G4
        113635,  // A4
        101238,  // B4
        95556    // C5
    };

    // True when every note count can be represented in cnt_w bits. Widths of
    // 32 or more always fit because the table entries are 32-bit values.
    function automatic bit note_table_fits(input int cnt_w);
        bit fits;
        fits = 1'b1;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (cnt_w < 32) begin
                if (NOTE_HALF[i] >= (32'd1 << cnt_w)) begin
                    fits = 1'b0;
                end
            end
        end
        return fits;
    endfunction

endpackage

// File: rtl/piano_note_scheduler_if.sv
// piano_note_scheduler_if: key inputs and tone-generator outputs of the scheduler.
//   key_raw               raw button levels, 1 = pressed, bit 0 = C4
//   counter_value_button  half-period count for pwm_signals
//   tone_en               audio gate, 1 = open
//   note_idx              index of the note held in counter_value_button
//   busy                  scheduler is in PLAY or GAP
// Modports: master drives the keys and observes the outputs; slave is the scheduler.
interface piano_note_scheduler_if #(
    parameter int NUM_KEYS = 8,
    parameter int CNT_W    = 20
);
    import piano_pkg::*;

    logic [NUM_KEYS-1:0] key_raw;
    logic [CNT_W-1:0]    counter_value_button;
    logic                tone_en;
    note_idx_t           note_idx;
    logic                busy;

    modport master (
        output key_raw,
        input  counter_value_button,
        input  tone_en,
        input  note_idx,
        input  busy
    );

    modport slave (
        input  key_raw,
        output counter_value_button,
        output tone_en,
        output note_idx,
        output busy
    );

endinterface

// File: rtl/piano_note_scheduler_key_debouncer.sv
// key_debouncer: debounces one raw button level.
//   new_clk_in  system clock
//   rst_n_in    synchronous active-low reset
//   key_raw     asynchronous button level
//   stable      debounced level; flips after DEBOUNCE_CYCLES consecutive
//               cycles in which the synchronised level disagrees with it
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic new_clk_in,
    input  logic rst_n_in,
    input  logic key_raw,
    output logic stable
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    logic [DB_W-1:0] db_cnt;

    // Two-stage synchroniser followed by a mismatch counter. Any cycle where
    // the synchronised level agrees with stable restarts the count, so only
    // an uninterrupted run of DEBOUNCE_CYCLES mismatches flips the output.
    // The counter never exceeds DB_LAST, so it cannot wrap.
    always_ff @(posedge new_clk_in) begin
        if (!rst_n_in) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            db_cnt <= '0;
            stable <= 1'b0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            if (sync2 != stable) begin
                if (db_cnt == DB_LAST) begin
                    stable <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/piano_note_scheduler.sv
// piano_note_scheduler: debounces the piano keys, picks the lowest held key
// and feeds its half-period count to the tone generator, with a silent gap
// between two different notes so each new note is re-articulated.
//   new_clk_in  system clock (100 MHz)
//   rst_n_in    synchronous active-low reset
//   bus         piano_note_scheduler_if.slave:
//                 key_raw (in), counter_value_button, tone_en, note_idx, busy (out)
module piano_note_scheduler
    import piano_pkg::*;
#(
    parameter int NUM_KEYS        = 8,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int GAP_CYCLES      = 2_000_000,
    parameter int CNT_W           = 20
) (
    input  logic                   new_clk_in,
    input  logic                   rst_n_in,
    piano_note_scheduler_if.slave  bus
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    // Refuse to elaborate with a count width too narrow for the note table.
    if (!note_table_fits(CNT_W)) begin : g_table_check
        $error("piano_note_scheduler: CNT_W too small for NOTE_HALF table");
    end

    logic [NUM_KEYS-1:0] key_stable;
    logic                any_key;
    note_idx_t           winner;
    sched_state_t        state;
    logic [GAP_W-1:0]    gap_cnt;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debouncer (
            .new_clk_in (new_clk_in),
            .rst_n_in   (rst_n_in),
            .key_raw    (bus.key_raw[k]),
            .stable     (key_stable[k])
        );
    end

    // Lowest-index held key wins; scanning downwards lets the lowest
    // match overwrite any higher one.
    always_comb begin
        winner  = '0;
        any_key = |key_stable;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_stable[i]) begin
                winner = note_idx_t'(i);
            end
        end
    end

    // Scheduler FSM with registered outputs. The tone count is only loaded
    // on the edge that enters PLAY, while the gate is closed, so the tone
    // generator never sees its count change mid-note. The reset value of
    // the count is a real note, never zero.
    always_ff @(posedge new_clk_in) begin
        if (!rst_n_in) begin
            state                    <= IDLE;
            gap_cnt                  <= '0;
            bus.tone_en              <= 1'b0;
            bus.busy                 <= 1'b0;
            bus.note_idx             <= '0;
            bus.counter_value_button <= CNT_W'(NOTE_HALF[0]);
        end else begin
            case (state)
                IDLE: begin
                    if (any_key) begin
                        state                    <= PLAY;
                        bus.note_idx             <= winner;
                        bus.counter_value_button <= CNT_W'(NOTE_HALF[winner]);
                        bus.tone_en              <= 1'b1;
                        bus.busy                 <= 1'b1;
                    end
                end
                PLAY: begin
                    if (!any_key) begin
                        state       <= IDLE;
                        bus.tone_en <= 1'b0;
                        bus.busy    <= 1'b0;
                    end else if (winner != bus.note_idx) begin
                        state       <= GAP;
                        bus.tone_en <= 1'b0;
                        gap_cnt     <= '0;
                    end
                end
                GAP: begin
                    // The gap length is fixed; key activity inside it only
                    // matters on the final cycle.
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (any_key) begin
                            state                    <= PLAY;
                            bus.note_idx             <= winner;
                            bus.counter_value_button <= CNT_W'(NOTE_HALF[winner]);
                            bus.tone_en              <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.tone_en <= 1'b0;
                    bus.busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piano_note_scheduler.sv
// tb_piano_note_scheduler: directed self-checking bench for piano_note_scheduler
// with DEBOUNCE_CYCLES = 4 and GAP_CYCLES = 3. Inputs change and outputs are
// sampled 1 time unit after a rising edge; "edge N" counts rising edges after
// the edge at which an input was changed.
module tb_piano_note_scheduler;

    localparam int NUM_KEYS = 8;
    localparam int CNT_W    = 20;

    localparam int HALF_C4 = 191109;
    localparam int HALF_D4 = 170264;
    localparam int HALF_F4 = 143171;
    localparam int HALF_G4 = 127550;
    localparam int HALF_A4 = 113635;
    localparam int HALF_C5 = 95556;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    piano_note_scheduler_if #(.NUM_KEYS(NUM_KEYS), .CNT_W(CNT_W)) bus ();

    piano_note_scheduler #(
        .NUM_KEYS        (NUM_KEYS),
        .DEBOUNCE_CYCLES (4),
        .GAP_CYCLES      (3),
        .CNT_W           (CNT_W)
    ) dut (
        .new_clk_in (clk),
        .rst_n_in   (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle just past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Full output snapshot compared against hand-computed values.
    task automatic check_all(input string tag, input logic ten, input logic bsy,
                             input int idx, input int val);
        check_output({tag, ".tone_en"}, 32'(bus.tone_en), 32'(ten));
        check_output({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
        check_output({tag, ".note_idx"}, 32'(bus.note_idx), idx);
        check_output({tag, ".value"}, 32'(bus.counter_value_button), val);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.key_raw = '0;

        // 1: reset held for three cycles, then released
        tick(3);
        rst_n = 1'b1;
        check_all("reset", 1'b0, 1'b0, 0, HALF_C4);
        tick(2);
        check_all("reset_idle", 1'b0, 1'b0, 0, HALF_C4);

        // 2: key 5 held; gate opens at edge 7, closes 7 edges after release
        bus.key_raw[5] = 1'b1;
        tick(6);
        check_all("k5_edge6", 1'b0, 1'b0, 0, HALF_C4);
        tick(1);
        check_all("k5_edge7", 1'b1, 1'b1, 5, HALF_A4);
        tick(3);
        check_all("k5_hold", 1'b1, 1'b1, 5, HALF_A4);
        bus.key_raw[5] = 1'b0;
        tick(6);
        check_all("k5_rel_edge6", 1'b1, 1'b1, 5, HALF_A4);
        tick(1);
        check_all("k5_rel_edge7", 1'b0, 1'b0, 5, HALF_A4);

        // 3: three-cycle glitch on key 2 never opens the gate
        bus.key_raw[2] = 1'b1;
        tick(3);
        bus.key_raw[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check_output("glitch.tone_busy", 32'({bus.tone_en, bus.busy}), 32'd0);
        end

        // 4: key 4 playing, key 1 pressed -> three silent cycles then note 1
        bus.key_raw = 8'b0001_0000;
        tick(7);
        check_all("k4_play", 1'b1, 1'b1, 4, HALF_G4);
        tick(2);
        bus.key_raw = 8'b0001_0010;
        tick(6);
        check_all("chg_edge6", 1'b1, 1'b1, 4, HALF_G4);
        tick(1);
        check_all("gap_edge7", 1'b0, 1'b1, 4, HALF_G4);
        tick(1);
        check_all("gap_edge8", 1'b0, 1'b1, 4, HALF_G4);
        tick(1);
        check_all("gap_edge9", 1'b0, 1'b1, 4, HALF_G4);
        tick(1);
        check_all("k1_edge10", 1'b1, 1'b1, 1, HALF_D4);
        tick(5);
        check_all("k1_over_k4", 1'b1, 1'b1, 1, HALF_D4);
        bus.key_raw = '0;
        tick(10);
        check_all("chg_released", 1'b0, 1'b0, 1, HALF_D4);

        // 5: keys 3+4 playing note 3; release 3 (gap starts), release 4 inside gap
        bus.key_raw = 8'b0001_1000;
        tick(7);
        check_all("k3_play", 1'b1, 1'b1, 3, HALF_F4);
        tick(2);
        bus.key_raw = 8'b0001_0000;
        tick(2);
        bus.key_raw = '0;
        tick(4);
        check_all("gaprel_edge6", 1'b1, 1'b1, 3, HALF_F4);
        tick(1);
        check_all("gaprel_edge7", 1'b0, 1'b1, 3, HALF_F4);
        tick(2);
        check_all("gaprel_edge9", 1'b0, 1'b1, 3, HALF_F4);
        tick(1);
        check_all("gaprel_idle", 1'b0, 1'b0, 3, HALF_F4);
        tick(3);
        check_all("gaprel_quiet", 1'b0, 1'b0, 3, HALF_F4);

        // 6: one-cycle reset while key 7 plays; replay at edge 7 after release
        bus.key_raw = 8'b1000_0000;
        tick(7);
        check_all("k7_play", 1'b1, 1'b1, 7, HALF_C5);
        tick(2);
        rst_n = 1'b0;
        tick(1);
        check_all("midreset", 1'b0, 1'b0, 0, HALF_C4);
        rst_n = 1'b1;
        tick(6);
        check_all("replay_edge6", 1'b0, 1'b0, 0, HALF_C4);
        tick(1);
        check_all("replay_edge7", 1'b1, 1'b1, 7, HALF_C5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piano_note_scheduler.md
Name: piano_note_scheduler

Overview:
- Sits between the piano key buttons and `pwm_signals`. It debounces NUM_KEYS raw key inputs and arbitrates between simultaneously held keys.
- It drives the tone generator's half-period count (`counter_value_button`) with the winning note's table value.
- It drives a gate (`tone_en`) that the top level ANDs with `pwm_audio`, so silence is real silence.
- On a note change it inserts a short silent gap so each new note is audibly re-articulated.

Parameters:
- NUM_KEYS, 8, number of key inputs; the note table covers C4..C5.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before a key change is accepted (10 ms at 100 MHz).
- GAP_CYCLES, 2_000_000, silent cycles inserted between two different notes (20 ms at 100 MHz).
- CNT_W, 20, width of the half-period count.

Ports:
- new_clk_in  in  1  system clock (100 MHz).
- rst_n_in  in  1  synchronous, active-low reset.
- key_raw  in  NUM_KEYS  asynchronous button levels; 1 = pressed; bit 0 = C4.
- counter_value_button  out  CNT_W  half-period count to `pwm_signals`.
- tone_en  out  1  1 = audio gate open.
- note_idx  out  3  index of the note currently held in `counter_value_button`.
- busy  out  1  high in PLAY or GAP.

Behaviour:
- Reset, decided: one clock `new_clk_in`; reset `rst_n_in` is synchronous and active-low. It is sampled only on the rising edge of `new_clk_in`.
- Reset values:
  - `tone_en` = 0, `busy` = 0, `note_idx` = 0.
  - `counter_value_button` = NOTE_HALF[0] (191109). It is never 0, so the tone generator never runs at f_clk/2.
  - All synchronisers, debounce counters and stable flags = 0; FSM = IDLE; gap counter = 0.
- Debounce, per key:
  - 2-FF synchroniser feeds `sync2`.
  - Counter increments on each edge where `sync2` != stable and clears on each edge where they are equal.
  - On an edge where there is a mismatch and counter == DEBOUNCE_CYCLES-1: stable flips and counter clears.
  - A raw level held from edge 0 appears on stable at edge 2+DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES is ignored.
- Arbitration:
  - Combinational winner = lowest index whose stable flag = 1.
  - `any_key` = OR of the stable flags.
- FSM, registered; outputs are updated on the same edge as the state change:
  - IDLE:
    - `any_key` → PLAY; load `note_idx` = winner and `counter_value_button` = NOTE_HALF[winner]; `tone_en` = 1.
  - PLAY:
    - !`any_key` → IDLE; `tone_en` = 0; value and `note_idx` hold.
    - winner != `note_idx` → GAP; `tone_en` = 0; gap counter = 0.
    - Otherwise stay in PLAY.
  - GAP:
    - Gap counter increments each cycle.
    - At gap counter == GAP_CYCLES-1: if `any_key`, load winner and go to PLAY with `tone_en` = 1; else go to IDLE.
    - Key changes during GAP do not extend the gap; the winner sampled on the final gap cycle is used.
- Latency:
  - Raw press to `tone_en` rise = DEBOUNCE_CYCLES+3 edges.
  - Note change = exactly GAP_CYCLES silent cycles.
- `counter_value_button` changes only on the edge that enters PLAY. It is never changed while `tone_en` = 1.
- Reset mid-note: on the first edge with `rst_n_in` = 0, all state goes to reset values and `tone_en` = 0 that cycle. Any in-progress debounce is discarded.
- `busy` = (state != IDLE).
- Widths:
  - The table holds CNT_W-bit unsigned values; all must be < 2^CNT_W. The package asserts this.
  - The debounce and gap counters are sized with $clog2 of their parameter. They saturate by construction (compare-and-clear); no wrap occurs.

Decomposition:
- Package `piano_pkg`:
  - NUM_NOTES = 8.
  - Note-index typedef.
  - FSM state enum {IDLE, PLAY, GAP}.
  - NOTE_HALF[8] = round(100e6/(2f)) - 1: 191109, 170264, 151684, 143171, 127550, 113635, 101238, 95556.
- One natural sub-module: `key_debouncer` (single bit: synchroniser plus counter plus stable flag), instantiated NUM_KEYS times with a generate loop.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, GAP_CYCLES=3.
1. Hold reset 3 cycles, then release → `tone_en`=0, `busy`=0, `counter_value_button`=191109, `note_idx`=0.
2. Raise `key_raw[5]` at edge 0 and hold → `tone_en` rises at edge 7, `note_idx`=5, `counter_value_button`=113635; release → `tone_en` falls 7 edges after release.
3. Pulse `key_raw[2]` high for 3 cycles only → `tone_en` stays 0 and `busy` stays 0 throughout.
4. Hold key 4 (playing), then press key 1 → `tone_en` low for exactly 3 cycles, then `note_idx`=1, value=170264; key 4 is ignored while key 1 is held.
5. In GAP, release all keys before the final gap cycle → IDLE, `tone_en` stays 0, `counter_value_button` unchanged.
6. Assert `rst_n_in`=0 for one cycle while key 7 is playing → next edge `tone_en`=0, `note_idx`=0, value=191109; with the key still held, replay starts at edge 7 after reset release.
